// File: rtl/mux2_arbiter.sv
// Round-robin arbiter for a shared 2:1 mux: grants one requester at a time, drives select s,
// and registers the selected word onto f with f_valid. Hold time is bounded only under contention.
module mux2_arbiter #(
  parameter int WIDTH    = 1,
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] w0,
  input  logic [WIDTH-1:0] w1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             s,
  output logic [WIDTH-1:0] f,
  output logic             f_valid
);

  localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s_q, s_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             f_valid_q, f_valid_d;

  logic             hold_expired;
  logic             xfer;
  logic [WIDTH-1:0] mux_out;

  assign hold_expired = (cnt_q == CNT_MAX);
  assign mux_out      = s_q ? w1 : w0;
  assign xfer         = ((state_q == OWN0) && req0) || ((state_q == OWN1) && req1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1) state_d = last_q ? OWN0 : OWN1;
        else if (req0)    state_d = OWN0;
        else if (req1)    state_d = OWN1;
      end
      OWN0: begin
        // A dropped request is evaluated before hold expiry; both yield the same owner.
        if (!req0)                     state_d = req1 ? OWN1 : IDLE;
        else if (req1 && hold_expired) state_d = OWN1;
      end
      OWN1: begin
        if (!req1)                     state_d = req0 ? OWN0 : IDLE;
        else if (req0 && hold_expired) state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    s_d    = s_q;
    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_d == OWN0) begin
        last_d = 1'b0;
        s_d    = 1'b0;
      end else if (state_d == OWN1) begin
        last_d = 1'b1;
        s_d    = 1'b1;
      end
    end else if (state_q != IDLE && !hold_expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    f_d       = f_q;
    f_valid_d = 1'b0;
    if (xfer) begin
      f_d       = mux_out;
      f_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      s_q       <= 1'b0;
      f_q       <= '0;
      f_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      s_q       <= s_d;
      f_q       <= f_d;
      f_valid_q <= f_valid_d;
    end
  end

  assign gnt0    = (state_q == OWN0);
  assign gnt1    = (state_q == OWN1);
  assign s       = s_q;
  assign f       = f_q;
  assign f_valid = f_valid_q;

endmodule
